decode_stage: RTL



---
 rtl/cpu_pkg.sv | 77 +++++++
 rtl/rf.sv | 35 +++
 rtl/decode_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcodes, ALU operation codes, immediate formats
// and the control bundle carried through the ID/EX register.
package cpu_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

   localparam logic [3:0] ALU_ADD     = 4'd0;
   localparam logic [3:0] ALU_SUB     = 4'd1;
   localparam logic [3:0] ALU_AND     = 4'd2;
   localparam logic [3:0] ALU_OR      = 4'd3;
   localparam logic [3:0] ALU_XOR     = 4'd4;
   localparam logic [3:0] ALU_SLT     = 4'd5;
   localparam logic [3:0] ALU_SLL     = 4'd6;
   localparam logic [3:0] ALU_SRL     = 4'd7;
   localparam logic [3:0] ALU_SRA     = 4'd8;
   localparam logic [3:0] ALU_SLTU    = 4'd9;
   localparam logic [3:0] ALU_PASSB   = 4'd10;
   localparam logic [3:0] ALU_INVALID = 4'd15;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_SHAMT,
      IMM_S,
      IMM_U,
      IMM_B
   } imm_sel_e;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       reg_write;
      logic       alu_src_imm;
      logic       mem_we;
      logic       mem_re;
      logic       mem_to_reg;
      logic       branch;
      logic       branch_ne;
      logic       illegal;
   } ctrl_t;

   // Shared funct3 map for R-type and OP-IMM; 'alt' selects SUB or SRA.
   function automatic logic [3:0] aluFromFunct3(input logic [2:0] funct3, input logic alt);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic [31:0] genImm(input logic [31:0] instr, input imm_sel_e sel);
      logic [31:0] imm;
      case (sel)
         IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
         IMM_SHAMT: imm = {27'b0, instr[24:20]};
         IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_U:     imm = {instr[31:12], 12'b0};
         IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default:   imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/rf.sv
// Architectural register file: one write port, two asynchronous read ports,
// register 0 hard-wired to zero.
module rf #(
   parameter int D_WIDTH = 32,
   parameter int N_REGS  = 32,
   parameter int RF_SIZE = $clog2(N_REGS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [RF_SIZE-1:0] waddr_i,
   input  logic [D_WIDTH-1:0] wdata_i,
   input  logic [RF_SIZE-1:0] raddr1_i,
   input  logic [RF_SIZE-1:0] raddr2_i,
   output logic [D_WIDTH-1:0] rdata1_o,
   output logic [D_WIDTH-1:0] rdata2_o
);

   logic [D_WIDTH-1:0] regs_q [N_REGS];

   // Writes to register 0 are dropped so it always reads back as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
   assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes the instruction word, reads the register file with WB
// bypass, detects load-use hazards and holds the ID/EX pipeline register.
module decode_stage
   import cpu_pkg::*;
#(
   parameter int D_WIDTH   = 32,
   parameter int N_REGS    = 32,
   parameter int RF_SIZE   = $clog2(N_REGS),
   parameter int OP_SIZE   = 4,
   parameter int WB_BYPASS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [D_WIDTH-1:0] instr,
   input  logic [D_WIDTH-1:0] pc,
   input  logic               flush,
   input  logic               ex_ready,
   input  logic               wb_we,
   input  logic [RF_SIZE-1:0] wb_rd,
   input  logic [D_WIDTH-1:0] wb_data,
   output logic               out_valid,
   output logic [D_WIDTH-1:0] pc_ex,
   output logic [D_WIDTH-1:0] rs1_val_ex,
   output logic [D_WIDTH-1:0] rs2_val_ex,
   output logic [D_WIDTH-1:0] imm_ex,
   output logic [RF_SIZE-1:0] rs1_ex,
   output logic [RF_SIZE-1:0] rs2_ex,
   output logic [RF_SIZE-1:0] rd_ex,
   output logic [OP_SIZE-1:0] alu_op_ex,
   output logic               reg_write_ex,
   output logic               alu_src_imm_ex,
   output logic               mem_we_ex,
   output logic               mem_re_ex,
   output logic               mem_to_reg_ex,
   output logic               branch_ex,
   output logic               branch_ne_ex,
   output logic               illegal_ex
);

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic [RF_SIZE-1:0] rs1Idx;
   logic [RF_SIZE-1:0] rs2Idx;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign rs1Idx = RF_SIZE'(instr[19:15]);
   assign rs2Idx = RF_SIZE'(instr[24:20]);

   ctrl_t              ctrlDec;
   imm_sel_e           immSel;
   logic [RF_SIZE-1:0] rdDec;
   logic               usesRs2;
   logic [D_WIDTH-1:0] immDec;

   // Instruction decoder. Stores and branches have no destination, so rd is
   // zeroed to keep them out of hazard and write-back comparisons downstream.
   always_comb begin
      ctrlDec = '0;
      immSel  = IMM_NONE;
      rdDec   = RF_SIZE'(instr[11:7]);
      usesRs2 = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            ctrlDec.reg_write = 1'b1;
            ctrlDec.alu_op    = aluFromFunct3(funct3, funct7 == FUNCT7_ALT);
            usesRs2           = 1'b1;
         end
         OPC_ITYPE: begin
            ctrlDec.reg_write   = 1'b1;
            ctrlDec.alu_src_imm = 1'b1;
            ctrlDec.alu_op      = aluFromFunct3(funct3, (funct3 == 3'b101) && instr[30]);
            immSel = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? IMM_SHAMT : IMM_I;
         end
         OPC_LOAD: begin
            ctrlDec.reg_write   = 1'b1;
            ctrlDec.alu_src_imm = 1'b1;
            ctrlDec.mem_re      = 1'b1;
            ctrlDec.mem_to_reg  = 1'b1;
            ctrlDec.alu_op      = ALU_ADD;
            immSel              = IMM_I;
         end
         OPC_STORE: begin
            ctrlDec.mem_we      = 1'b1;
            ctrlDec.alu_src_imm = 1'b1;
            ctrlDec.alu_op      = ALU_ADD;
            immSel              = IMM_S;
            rdDec               = '0;
            usesRs2             = 1'b1;
         end
         OPC_LUI: begin
            ctrlDec.reg_write   = 1'b1;
            ctrlDec.alu_src_imm = 1'b1;
            ctrlDec.alu_op      = ALU_PASSB;
            immSel              = IMM_U;
         end
         OPC_BRANCH: begin
            rdDec   = '0;
            usesRs2 = 1'b1;
            if (funct3[2:1] == 2'b00) begin
               ctrlDec.branch    = 1'b1;
               ctrlDec.branch_ne = funct3[0];
               ctrlDec.alu_op    = ALU_SUB;
               immSel            = IMM_B;
            end else begin
               ctrlDec.illegal = 1'b1;
               ctrlDec.alu_op  = ALU_INVALID;
            end
         end
         default: begin
            ctrlDec.illegal = 1'b1;
            ctrlDec.alu_op  = ALU_INVALID;
         end
      endcase
   end

   assign immDec = D_WIDTH'(genImm(instr, immSel));

   logic [D_WIDTH-1:0] rfRd1;
   logic [D_WIDTH-1:0] rfRd2;
   logic [D_WIDTH-1:0] rs1Val;
   logic [D_WIDTH-1:0] rs2Val;

   rf #(
      .D_WIDTH (D_WIDTH),
      .N_REGS  (N_REGS),
      .RF_SIZE (RF_SIZE)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .we_i     (wb_we),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data),
      .raddr1_i (rs1Idx),
      .raddr2_i (rs2Idx),
      .rdata1_o (rfRd1),
      .rdata2_o (rfRd2)
   );

   // The register file only commits at the edge, so a write landing in the
   // decode cycle is forwarded here to avoid reading the stale value.
   always_comb begin
      rs1Val = rfRd1;
      rs2Val = rfRd2;
      if ((WB_BYPASS != 0) && wb_we && (wb_rd != '0)) begin
         if (wb_rd == rs1Idx) rs1Val = wb_data;
         if (wb_rd == rs2Idx) rs2Val = wb_data;
      end
   end

   logic               valid_q,   valid_d;
   ctrl_t              ctrl_q,    ctrl_d;
   logic [D_WIDTH-1:0] pc_q,      pc_d;
   logic [D_WIDTH-1:0] rs1Val_q,  rs1Val_d;
   logic [D_WIDTH-1:0] rs2Val_q,  rs2Val_d;
   logic [D_WIDTH-1:0] imm_q,     imm_d;
   logic [RF_SIZE-1:0] rs1_q,     rs1_d;
   logic [RF_SIZE-1:0] rs2_q,     rs2_d;
   logic [RF_SIZE-1:0] rd_q,      rd_d;

   logic loadUse;
   logic hazard;
   logic stall;

   // A load sitting in ID/EX cannot supply its data to the very next
   // instruction, so that instruction waits for exactly one bubble.
   assign loadUse = valid_q && ctrl_q.mem_re && (rd_q != '0) &&
                    ((rd_q == rs1Idx) || (usesRs2 && (rd_q == rs2Idx)));
   assign hazard  = in_valid && loadUse;
   assign stall   = valid_q && !ex_ready;
   assign in_ready = !rst && !flush && !stall && !hazard;

   // Next-state selection: flush beats stall, stall beats load, otherwise drain
   // to a bubble with all control flags cleared.
   always_comb begin
      valid_d  = valid_q;
      ctrl_d   = ctrl_q;
      pc_d     = pc_q;
      rs1Val_d = rs1Val_q;
      rs2Val_d = rs2Val_q;
      imm_d    = imm_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         if (in_valid && in_ready) begin
            valid_d  = 1'b1;
            ctrl_d   = ctrlDec;
            pc_d     = pc;
            rs1Val_d = rs1Val;
            rs2Val_d = rs2Val;
            imm_d    = immDec;
            rs1_d    = rs1Idx;
            rs2_d    = rs2Idx;
            rd_d     = rdDec;
         end else begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         pc_q     <= '0;
         rs1Val_q <= '0;
         rs2Val_q <= '0;
         imm_q    <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
      end else begin
         valid_q  <= valid_d;
         ctrl_q   <= ctrl_d;
         pc_q     <= pc_d;
         rs1Val_q <= rs1Val_d;
         rs2Val_q <= rs2Val_d;
         imm_q    <= imm_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
      end
   end

   assign out_valid      = valid_q;
   assign pc_ex          = pc_q;
   assign rs1_val_ex     = rs1Val_q;
   assign rs2_val_ex     = rs2Val_q;
   assign imm_ex         = imm_q;
   assign rs1_ex         = rs1_q;
   assign rs2_ex         = rs2_q;
   assign rd_ex          = rd_q;
   assign alu_op_ex      = OP_SIZE'(ctrl_q.alu_op);
   assign reg_write_ex   = ctrl_q.reg_write;
   assign alu_src_imm_ex = ctrl_q.alu_src_imm;
   assign mem_we_ex      = ctrl_q.mem_we;
   assign mem_re_ex      = ctrl_q.mem_re;
   assign mem_to_reg_ex  = ctrl_q.mem_to_reg;
   assign branch_ex      = ctrl_q.branch;
   assign branch_ne_ex   = ctrl_q.branch_ne;
   assign illegal_ex     = ctrl_q.illegal;

endmodule
